// File: rtl/csm_pkg.sv
// rtl/csm_pkg.sv - shared types for the hold/release arbitrated shared memory
//   Opcode, error, lock-owner and FSM state enums plus the per-port request
//   and response structs used by csm_shared_mem and csm_lock_fsm.
//   The struct field widths follow CSM_ADDR_W / CSM_DATA_W. The top module's
//   ADDR_W / DATA_W parameters must stay equal to these values.

package csm_pkg;

    localparam int CSM_ADDR_W = 2;
    localparam int CSM_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_HOLD    = 2'b10,
        OP_RELEASE = 2'b11
    } csm_op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_LOCKED    = 2'b01,
        ERR_CONFLICT  = 2'b10,
        ERR_NOT_OWNER = 2'b11
    } csm_err_e;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'b00,
        LOCK_A    = 2'b01,
        LOCK_B    = 2'b10
    } csm_lock_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HELD_A = 2'b01,
        ST_HELD_B = 2'b10
    } csm_state_e;

    typedef struct packed {
        logic                  req;
        csm_op_e               op;
        logic [CSM_ADDR_W-1:0] addr;
        logic [CSM_DATA_W-1:0] wdata;
    } csm_req_t;

    typedef struct packed {
        logic                  ack;
        logic                  err;
        csm_err_e              err_code;
        logic [CSM_DATA_W-1:0] rdata;
    } csm_rsp_t;

endpackage

// File: rtl/csm_lock_fsm.sv
// rtl/csm_lock_fsm.sv - hold/release lock FSM with idle timeout and A-priority tie-break
//   clk, reset            : clock, synchronous active-high reset
//   a_req/a_op, b_req/b_op: per-port request valid and opcode
//   a_allowed, b_allowed  : request present and not blocked by the lock (combinational)
//   lock_owner            : registered current owner (csm_lock_e)
//   hold_timeout          : one-cycle pulse when a hold is force-released

module csm_lock_fsm
    import csm_pkg::*;
#(
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic [1:0] a_op,
    input  logic       b_req,
    input  logic [1:0] b_op,
    output logic       a_allowed,
    output logic       b_allowed,
    output logic [1:0] lock_owner,
    output logic       hold_timeout
);

    localparam bit TO_EN = (HOLD_TIMEOUT > 0);
    localparam int CNT_W = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

    csm_state_e       state;
    logic [CNT_W-1:0] idle_cnt;

    logic a_hold;
    logic b_hold;

    assign a_hold = a_req && (csm_op_e'(a_op) == OP_HOLD);
    assign b_hold = b_req && (csm_op_e'(b_op) == OP_HOLD);

    // Everything is judged against the state at the start of the cycle.
    // A simultaneous HOLD from IDLE goes to A; B's HOLD is then refused.
    assign a_allowed = a_req && (state != ST_HELD_B);
    assign b_allowed = b_req && (state != ST_HELD_A) &&
                       !((state == ST_IDLE) && a_hold && b_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            idle_cnt     <= '0;
            lock_owner   <= LOCK_NONE;
            hold_timeout <= 1'b0;
        end else begin
            hold_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (a_allowed && a_hold) begin
                        state      <= ST_HELD_A;
                        lock_owner <= LOCK_A;
                    end else if (b_allowed && b_hold) begin
                        state      <= ST_HELD_B;
                        lock_owner <= LOCK_B;
                    end
                end
                ST_HELD_A: begin
                    // Any owner request is served and restarts the idle window,
                    // which also wins over a timeout falling in the same cycle.
                    if (a_req) begin
                        idle_cnt <= '0;
                        if (csm_op_e'(a_op) == OP_RELEASE) begin
                            state      <= ST_IDLE;
                            lock_owner <= LOCK_NONE;
                        end
                    end else if (TO_EN && (idle_cnt == CNT_LAST)) begin
                        idle_cnt     <= '0;
                        state        <= ST_IDLE;
                        lock_owner   <= LOCK_NONE;
                        hold_timeout <= 1'b1;
                    end else if (TO_EN) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_HELD_B: begin
                    if (b_req) begin
                        idle_cnt <= '0;
                        if (csm_op_e'(b_op) == OP_RELEASE) begin
                            state      <= ST_IDLE;
                            lock_owner <= LOCK_NONE;
                        end
                    end else if (TO_EN && (idle_cnt == CNT_LAST)) begin
                        idle_cnt     <= '0;
                        state        <= ST_IDLE;
                        lock_owner   <= LOCK_NONE;
                        hold_timeout <= 1'b1;
                    end else if (TO_EN) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    idle_cnt   <= '0;
                    lock_owner <= LOCK_NONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/csm_shared_mem.sv
// rtl/csm_shared_mem.sv - dual-port shared register file with hold/release arbitration
//   clk, reset                         : clock, synchronous active-high reset
//   a_req/a_op/a_addr/a_wdata          : port A request (single-cycle, no backpressure)
//   a_ack/a_err/a_err_code/a_rdata     : port A registered response, one cycle after request
//   b_*                                : same for port B
//   lock_owner                         : current owner (csm_lock_e)
//   hold_timeout                       : one-cycle pulse on forced release

module csm_shared_mem
    import csm_pkg::*;
#(
    parameter int ADDR_W       = CSM_ADDR_W,
    parameter int DATA_W       = CSM_DATA_W,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [1:0]        a_op,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [1:0]        a_err_code,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [1:0]        b_op,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [1:0]        b_err_code,
    output logic [DATA_W-1:0] b_rdata,
    output logic [1:0]        lock_owner,
    output logic              hold_timeout
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    csm_req_t a_q;
    csm_req_t b_q;
    csm_rsp_t a_nxt;
    csm_rsp_t b_nxt;
    csm_rsp_t a_rsp;
    csm_rsp_t b_rsp;

    logic a_allowed;
    logic b_allowed;
    logic a_wr;
    logic b_wr;

    assign a_q = '{req: a_req, op: csm_op_e'(a_op), addr: a_addr, wdata: a_wdata};
    assign b_q = '{req: b_req, op: csm_op_e'(b_op), addr: b_addr, wdata: b_wdata};

    csm_lock_fsm #(
        .HOLD_TIMEOUT (HOLD_TIMEOUT)
    ) u_lock (
        .clk          (clk),
        .reset        (reset),
        .a_req        (a_req),
        .a_op         (a_op),
        .b_req        (b_req),
        .b_op         (b_op),
        .a_allowed    (a_allowed),
        .b_allowed    (b_allowed),
        .lock_owner   (lock_owner),
        .hold_timeout (hold_timeout)
    );

    // lock_owner is the FSM state as of the start of this cycle, so an
    // allowed RELEASE is from the owner unless the lock is free.
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        a_wr  = 1'b0;
        b_wr  = 1'b0;

        if (a_q.req) begin
            a_nxt.ack = 1'b1;
            if (!a_allowed) begin
                a_nxt.err      = 1'b1;
                a_nxt.err_code = ERR_LOCKED;
            end else begin
                case (a_q.op)
                    OP_READ:    a_nxt.rdata = mem[a_q.addr];
                    OP_WRITE:   a_wr = 1'b1;
                    OP_HOLD:    ;
                    OP_RELEASE: begin
                        if (lock_owner != LOCK_A) begin
                            a_nxt.err      = 1'b1;
                            a_nxt.err_code = ERR_NOT_OWNER;
                        end
                    end
                    default:    ;
                endcase
            end
        end

        if (b_q.req) begin
            b_nxt.ack = 1'b1;
            if (!b_allowed) begin
                b_nxt.err      = 1'b1;
                b_nxt.err_code = ERR_LOCKED;
            end else begin
                case (b_q.op)
                    OP_READ:    b_nxt.rdata = mem[b_q.addr];
                    OP_WRITE: begin
                        // Same-address write collision: A keeps the word.
                        if (a_wr && (a_q.addr == b_q.addr)) begin
                            b_nxt.err      = 1'b1;
                            b_nxt.err_code = ERR_CONFLICT;
                        end else begin
                            b_wr = 1'b1;
                        end
                    end
                    OP_HOLD:    ;
                    OP_RELEASE: begin
                        if (lock_owner != LOCK_B) begin
                            b_nxt.err      = 1'b1;
                            b_nxt.err_code = ERR_NOT_OWNER;
                        end
                    end
                    default:    ;
                endcase
            end
        end
    end

    // Reads above sample mem before these non-blocking writes land, so a
    // same-cycle READ/WRITE pair returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            a_rsp <= '0;
            b_rsp <= '0;
        end else begin
            a_rsp <= a_nxt;
            b_rsp <= b_nxt;
            if (a_wr) begin
                mem[a_q.addr] <= a_q.wdata;
            end
            if (b_wr) begin
                mem[b_q.addr] <= b_q.wdata;
            end
        end
    end

    assign a_ack      = a_rsp.ack;
    assign a_err      = a_rsp.err;
    assign a_err_code = a_rsp.err_code;
    assign a_rdata    = a_rsp.rdata;
    assign b_ack      = b_rsp.ack;
    assign b_err      = b_rsp.err;
    assign b_err_code = b_rsp.err_code;
    assign b_rdata    = b_rsp.rdata;

endmodule

// File: tb/tb_csm_shared_mem.sv
// tb/tb_csm_shared_mem.sv - self-checking bench for csm_shared_mem

module tb_csm_shared_mem;

    localparam int T = 8;
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, HLD = 2'd2, REL = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, b_req;
    logic [1:0] a_op, b_op, a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, a_err, b_ack, b_err;
    logic [1:0] a_err_code, b_err_code, lock_owner;
    logic [7:0] a_rdata, b_rdata;
    logic       hold_timeout;

    always #5 clk = ~clk;

    csm_shared_mem #(.ADDR_W(2), .DATA_W(8), .HOLD_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_err_code(a_err_code), .a_rdata(a_rdata),
        .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_err_code(b_err_code), .b_rdata(b_rdata),
        .lock_owner(lock_owner), .hold_timeout(hold_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: owner 0=none 1=A 2=B, last_touch = edge index of last owner activity.
    logic [7:0] m_mem [4];
    int         m_owner = 0;
    int         m_last  = 0;
    int         cyc     = 0;

    logic       ea_ack, ea_err, eb_ack, eb_err, e_to;
    logic [1:0] ea_code, eb_code;
    logic [7:0] ea_rd, eb_rd;
    int         e_owner;

    task automatic model();
        int  o, n_owner;
        bit  a_wr, b_wr, touch;
        ea_ack = 0; ea_err = 0; ea_code = 0; ea_rd = 0;
        eb_ack = 0; eb_err = 0; eb_code = 0; eb_rd = 0;
        e_to = 0;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
            m_owner = 0;
            m_last  = cyc;
        end else begin
            o = m_owner; n_owner = o; a_wr = 0; b_wr = 0;
            if (a_req) begin
                ea_ack = 1;
                if (o == 2) begin ea_err = 1; ea_code = 2'd1; end
                else if (a_op == RD) ea_rd = m_mem[a_addr];
                else if (a_op == WR) a_wr = 1;
                else if (a_op == HLD) n_owner = 1;
                else if (o == 1) n_owner = 0;
                else begin ea_err = 1; ea_code = 2'd3; end
            end
            if (b_req) begin
                eb_ack = 1;
                if (o == 1) begin eb_err = 1; eb_code = 2'd1; end
                else if (b_op == RD) eb_rd = m_mem[b_addr];
                else if (b_op == WR) begin
                    if (a_wr && a_addr == b_addr) begin eb_err = 1; eb_code = 2'd2; end
                    else b_wr = 1;
                end else if (b_op == HLD) begin
                    if (o == 0 && a_req && a_op == HLD) begin eb_err = 1; eb_code = 2'd1; end
                    else n_owner = 2;
                end else if (o == 2) n_owner = 0;
                else begin eb_err = 1; eb_code = 2'd3; end
            end
            touch = (o == 1 && a_req) || (o == 2 && b_req);
            if (n_owner != o || touch) m_last = cyc;
            else if (o != 0 && cyc - m_last == T) begin
                n_owner = 0;
                e_to = 1;
            end
            if (a_wr) m_mem[a_addr] = a_wdata;
            if (b_wr) m_mem[b_addr] = b_wdata;
            m_owner = n_owner;
        end
        e_owner = m_owner;
        cyc++;
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
        check("a_ack", 32'(a_ack), 32'(ea_ack));
        check("a_err", 32'(a_err), 32'(ea_err));
        check("a_err_code", 32'(a_err_code), 32'(ea_code));
        check("a_rdata", 32'(a_rdata), 32'(ea_rd));
        check("b_ack", 32'(b_ack), 32'(eb_ack));
        check("b_err", 32'(b_err), 32'(eb_err));
        check("b_err_code", 32'(b_err_code), 32'(eb_code));
        check("b_rdata", 32'(b_rdata), 32'(eb_rd));
        check("lock_owner", 32'(lock_owner), 32'(e_owner));
        check("hold_timeout", 32'(hold_timeout), 32'(e_to));
    endtask

    task automatic drive_a(input logic req, input logic [1:0] op, input logic [1:0] addr, input logic [7:0] wd);
        a_req = req; a_op = op; a_addr = addr; a_wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic [1:0] op, input logic [1:0] addr, input logic [7:0] wd);
        b_req = req; b_op = op; b_addr = addr; b_wdata = wd;
    endtask

    task automatic drive_idle();
        drive_a(0, RD, 0, 0);
        drive_b(0, RD, 0, 0);
    endtask

    initial begin
        int n;
        bit seen;
        int dens;
        reset = 1;
        drive_idle();
        step();
        step();
        reset = 0;
        check("rst_owner", 32'(lock_owner), 32'd0);
        check("rst_a_ack", 32'(a_ack), 32'd0);

        // write then read back
        drive_a(1, WR, 1, 8'hFF); step();
        drive_a(1, RD, 1, 0); step();
        check("t1_ack", 32'(a_ack), 32'd1);
        check("t1_rdata", 32'(a_rdata), 32'hFF);
        check("t1_err", 32'(a_err), 32'd0);

        // hold blocks the other port
        drive_idle(); drive_a(1, HLD, 0, 0); step();
        drive_idle(); drive_b(1, RD, 2, 0); step();
        check("t2_b_err", 32'(b_err), 32'd1);
        check("t2_b_code", 32'(b_err_code), 32'd1);
        check("t2_owner", 32'(lock_owner), 32'd1);
        drive_idle(); drive_a(1, REL, 0, 0); step();
        drive_idle(); drive_b(1, RD, 2, 0); step();
        check("t2_b_ok", 32'(b_err), 32'd0);
        check("t2_b_rdata", 32'(b_rdata), 32'h00);

        // simultaneous hold tie-break
        drive_a(1, HLD, 0, 0); drive_b(1, HLD, 0, 0); step();
        check("t3_a_err", 32'(a_err), 32'd0);
        check("t3_b_code", 32'(b_err_code), 32'd1);
        check("t3_owner", 32'(lock_owner), 32'd1);
        drive_idle(); drive_a(1, REL, 0, 0); step();

        // write collisions
        drive_a(1, WR, 3, 8'h12); drive_b(1, WR, 3, 8'h34); step();
        check("t4_b_code", 32'(b_err_code), 32'd2);
        drive_idle(); drive_a(1, RD, 3, 0); step();
        check("t4_rd3", 32'(a_rdata), 32'h12);
        drive_a(1, WR, 0, 8'hAA); drive_b(1, WR, 1, 8'hBB); step();
        drive_a(1, RD, 0, 0); drive_b(1, RD, 1, 0); step();
        check("t4_rd0", 32'(a_rdata), 32'hAA);
        check("t4_rd1", 32'(b_rdata), 32'hBB);

        // hold timeout
        drive_idle(); drive_a(1, HLD, 0, 0); step();
        drive_idle();
        n = 0; seen = 0;
        while (n < 20 && !seen) begin
            step();
            n++;
            seen = hold_timeout;
        end
        check("t5_delay", 32'(n), 32'd8);
        check("t5_owner", 32'(lock_owner), 32'd0);
        drive_b(1, WR, 2, 8'h77); step();
        check("t5_b_wr", 32'(b_err), 32'd0);

        // reset during a hold with a write in flight
        drive_idle(); drive_a(1, HLD, 0, 0); step();
        drive_a(1, WR, 0, 8'h55); reset = 1; step();
        check("t6_ack", 32'(a_ack), 32'd0);
        check("t6_owner", 32'(lock_owner), 32'd0);
        reset = 0;
        drive_a(1, RD, 0, 0); step();
        check("t6_rd0", 32'(a_rdata), 32'h00);

        // randomized traffic at several request densities
        for (int ph = 0; ph < 6; ph++) begin
            dens = (ph % 3 == 0) ? 8 : (ph % 3 == 1) ? 40 : 85;
            for (int k = 0; k < 400; k++) begin
                reset = ($urandom_range(0, 299) == 0);
                drive_a($urandom_range(0, 99) < dens, 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 8'($urandom));
                drive_b($urandom_range(0, 99) < dens, 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 8'($urandom));
                step();
            end
        end
        reset = 0;
        drive_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
